// File: rtl/divider_param.sv
// Sequential non-restoring integer divider, one quotient bit per clock.
// Signed (truncating) or unsigned per operation, with start/busy/done handshake and error flags.
module divider_param #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CORRECT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    count_r;
    logic [WIDTH:0]   acc_r;       // signed partial remainder
    logic [WIDTH-1:0] quo_r;       // quotient bits; holds raw dividend on the divide-by-zero path
    logic [WIDTH:0]   dsr_r;       // divisor magnitude
    logic             q_neg_r;
    logic             r_neg_r;
    logic             dbz_r;
    logic             ovf_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_flag_r;
    logic             ovf_flag_r;

    logic             sign_a_s;
    logic             sign_b_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   acc_step_s;
    logic [WIDTH-1:0] acc_fix_s;

    // Operand magnitudes at capture; -MIN wraps to MIN, which read unsigned is exactly 2^(WIDTH-1)
    always_comb begin
        sign_a_s = signed_op & dividend[WIDTH-1];
        sign_b_s = signed_op & divisor[WIDTH-1];
        if (sign_a_s) begin
            mag_a_s = ZERO_W - dividend;
        end else begin
            mag_a_s = dividend;
        end
        if (sign_b_s) begin
            mag_b_s = ZERO_W - divisor;
        end else begin
            mag_b_s = divisor;
        end
    end

    // One non-restoring step and the final remainder fix-up; wrap of the shifted value is harmless modulo 2^(WIDTH+1)
    always_comb begin
        shifted_s = {acc_r[WIDTH-1:0], quo_r[WIDTH-1]};
        if (acc_r[WIDTH]) begin
            acc_step_s = shifted_s + dsr_r;
            acc_fix_s  = acc_r[WIDTH-1:0] + dsr_r[WIDTH-1:0];
        end else begin
            acc_step_s = shifted_s - dsr_r;
            acc_fix_s  = acc_r[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (divisor == ZERO_W) ? CORRECT : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == LAST_ITER) begin
                    state_nxt_s = CORRECT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            CORRECT: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath, handshake and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r     <= {CW{1'b0}};
            acc_r       <= {(WIDTH+1){1'b0}};
            quo_r       <= ZERO_W;
            dsr_r       <= {(WIDTH+1){1'b0}};
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= ZERO_W;
            remainder_r <= ZERO_W;
            dbz_flag_r  <= 1'b0;
            ovf_flag_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy_r  <= 1'b1;
                        count_r <= {CW{1'b0}};
                        acc_r   <= {(WIDTH+1){1'b0}};
                        dsr_r   <= {1'b0, mag_b_s};
                        q_neg_r <= sign_a_s ^ sign_b_s;
                        r_neg_r <= sign_a_s;
                        dbz_r   <= (divisor == ZERO_W);
                        ovf_r   <= signed_op & (dividend == MIN_VAL) & (divisor == ALL_ONES);
                        quo_r   <= (divisor == ZERO_W) ? dividend : mag_a_s;
                    end
                end
                RUN: begin
                    acc_r   <= acc_step_s;
                    quo_r   <= {quo_r[WIDTH-2:0], ~acc_step_s[WIDTH]};
                    count_r <= count_r + CW'(1);
                end
                CORRECT: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    count_r <= {CW{1'b0}};
                    if (dbz_r) begin
                        quotient_r  <= ALL_ONES;
                        remainder_r <= quo_r;
                        dbz_flag_r  <= 1'b1;
                        ovf_flag_r  <= 1'b0;
                    end else if (ovf_r) begin
                        quotient_r  <= MIN_VAL;
                        remainder_r <= ZERO_W;
                        dbz_flag_r  <= 1'b0;
                        ovf_flag_r  <= 1'b1;
                    end else begin
                        quotient_r  <= q_neg_r ? (ZERO_W - quo_r) : quo_r;
                        remainder_r <= r_neg_r ? (ZERO_W - acc_fix_s) : acc_fix_s;
                        dbz_flag_r  <= 1'b0;
                        ovf_flag_r  <= 1'b0;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_flag_r;
    assign overflow    = ovf_flag_r;

endmodule

// File: tb/tb_divider_param.sv
// Self-checking bench for divider_param: directed table, multi-cycle corner sequences,
// and a randomized sweep on WIDTH=32 and WIDTH=8 instances against an arithmetic model.
module tb_divider_param;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start32, sop32, busy32, done32, dbz32, ovf32;
    logic [31:0] a32, b32, q32, r32;
    logic        start8, sop8, busy8, done8, dbz8, ovf8;
    logic [7:0]  a8, b8, q8, r8;

    int vectors = 0;
    int miscompares = 0;
    int cyc_cnt = 0;
    int t0 = 0;

    typedef struct {
        logic        s;
        logic [31:0] a, b, q, r;
        logic        dbz, ovf;
    } vec_t;

    vec_t tbl[9];

    divider_param #(.WIDTH(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .start(start32), .signed_op(sop32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(dbz32), .overflow(ovf32)
    );

    divider_param #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .signed_op(sop8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8), .overflow(ovf8)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: plain truncating / and % on sign-interpreted values of width w
    function automatic void ref_div(input int w, input logic s, input logic [31:0] a_in,
                                    input logic [31:0] b_in, output logic [31:0] q,
                                    output logic [31:0] r, output logic dbz, output logic ovf);
        longint mask = (longint'(1) << w) - 1;
        longint ua = longint'(a_in) & mask;
        longint ub = longint'(b_in) & mask;
        longint sa = ua;
        longint sb = ub;
        longint qq, rr;
        dbz = 1'b0;
        ovf = 1'b0;
        if (ub == 0) begin
            dbz = 1'b1;
            qq = mask;
            rr = ua;
        end else begin
            if (s) begin
                if ((ua >> (w - 1)) != 0) sa = ua - (longint'(1) << w);
                if ((ub >> (w - 1)) != 0) sb = ub - (longint'(1) << w);
            end
            qq = sa / sb;
            rr = sa % sb;
            if (s && sa == -(longint'(1) << (w - 1)) && sb == -1) ovf = 1'b1;
        end
        q = 32'(qq & mask);
        r = 32'(rr & mask);
    endfunction

    task automatic launch(input bit w8, input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        if (w8) begin
            start8 = 1'b1; sop8 = s; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = 1'b1; sop32 = s; a32 = a; b32 = b;
        end
        @(posedge clock);
        #1;
        t0 = cyc_cnt;
        start8 = 1'b0;
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
        sop32 = ~sop32; sop8 = ~sop8;
    endtask

    task automatic wait_done(input bit w8, output int lat);
        int n = 0;
        while (!(w8 ? done8 : done32) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: no done within %0d cycles", n);
        end
        lat = cyc_cnt - t0;
    endtask

    task automatic run_check(input bit w8, input logic s, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eq, input logic [31:0] er,
                             input logic edbz, input logic eovf, input string tag);
        int lat;
        int w = w8 ? 8 : 32;
        logic [31:0] bm;
        bm = w8 ? {24'd0, b[7:0]} : b;
        launch(w8, s, a, b);
        chk({tag, " busy"}, {31'd0, w8 ? busy8 : busy32}, 32'd1);
        wait_done(w8, lat);
        chk({tag, " latency"}, 32'(lat), (bm == 32'd0) ? 32'd1 : 32'(w + 1));
        chk({tag, " quotient"}, w8 ? {24'd0, q8} : q32, eq);
        chk({tag, " remainder"}, w8 ? {24'd0, r8} : r32, er);
        chk({tag, " flags"}, {30'd0, w8 ? dbz8 : dbz32, w8 ? ovf8 : ovf32}, {30'd0, edbz, eovf});
    endtask

    initial begin
        int lat;
        int seen;
        logic s;
        logic [31:0] a, b, eq, er;
        logic edbz, eovf;
        bit w8;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 1'b0};
        tbl[4] = '{1'b0, 32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b1, 1'b0};
        tbl[5] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1};
        tbl[7] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 1'b0};
        tbl[8] = '{1'b1, 32'hFFFFFF00,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF00,   1'b1, 1'b0};

        reset_n = 1'b0;
        start32 = 1'b0; sop32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
        start8 = 1'b0; sop8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset outputs32", {busy32, done32, dbz32, ovf32, q32 | r32}, 36'd0);
        chk("reset outputs8", {20'd0, busy8, done8, dbz8, ovf8, q8 | r8}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_check(1'b0, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                      tbl[i].dbz, tbl[i].ovf, $sformatf("tbl%0d", i));
        end

        // start pulsed mid-RUN must be ignored; previous result held meanwhile
        launch(1'b0, 1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clock);
        #1;
        chk("held quotient", q32, 32'hFFFFFFFF);
        @(negedge clock);
        start32 = 1'b1; a32 = 32'd7; b32 = 32'd2; sop32 = 1'b1;
        @(posedge clock);
        #1;
        start32 = 1'b0;
        wait_done(1'b0, lat);
        chk("midrun latency", 32'(lat), 32'd33);
        chk("midrun quotient", q32, 32'd333);
        chk("midrun remainder", r32, 32'd1);

        // start in the done cycle is accepted back-to-back
        launch(1'b0, 1'b0, 32'd100, 32'd7);
        wait_done(1'b0, lat);
        start32 = 1'b1; sop32 = 1'b0; a32 = 32'd200; b32 = 32'd9;
        @(posedge clock);
        #1;
        t0 = cyc_cnt;
        start32 = 1'b0;
        chk("b2b done pulse", {31'd0, done32}, 32'd0);
        chk("b2b accepted", {31'd0, busy32}, 32'd1);
        chk("b2b first q", q32, 32'd14);
        wait_done(1'b0, lat);
        chk("b2b latency", 32'(lat), 32'd33);
        chk("b2b quotient", q32, 32'd22);
        chk("b2b remainder", r32, 32'd2);

        // asynchronous reset in the middle of RUN
        launch(1'b0, 1'b1, 32'hFFFFF000, 32'd5);
        repeat (5) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset outputs", {busy32, done32, dbz32, ovf32, q32 | r32}, 36'd0);
        #4 reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (done32 || busy32) seen++;
        end
        chk("no done after reset", 32'(seen), 32'd0);

        // randomized sweep over both widths
        for (int i = 0; i < 80; i++) begin
            w8 = (i % 2) == 1;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = w8 ? 32'h80 : 32'h80000000;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            ref_div(w8 ? 8 : 32, s, a, b, eq, er, edbz, eovf);
            run_check(w8, s, a, b, eq, er, edbz, eovf, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
